// File: rtl/fft_stage_ctrl.sv
// Sequencer for an in-place 512-point radix-2 DIT FFT: 9 stages x 256 butterflies, one per cycle.
// Reads issue one cycle after start; writes trail reads by BF_LAT cycles; no backpressure.
module fft_stage_ctrl #(
    parameter int BF_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [3:0] stage,
    output logic       rd_en,
    output logic [8:0] rd_addr1,
    output logic [8:0] rd_addr2,
    output logic [7:0] tw_addr,
    output logic       wr_en,
    output logic [8:0] wr_addr1,
    output logic [8:0] wr_addr2
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [8:0] a1;
        logic [8:0] a2;
        logic [7:0] tw;
    } addr_t;

    state_t     state;
    logic [7:0] b;
    logic [3:0] dcnt;

    logic       vld_pipe [BF_LAT];
    logic [8:0] a1_pipe  [BF_LAT];
    logic [8:0] a2_pipe  [BF_LAT];

    function automatic addr_t gen_addr(input logic [3:0] s, input logic [7:0] bi);
        logic [8:0] bw;
        logic [8:0] half;
        logic [8:0] pos;
        addr_t      r;
        bw   = {1'b0, bi};
        half = 9'd1 << s;
        pos  = bw & (half - 9'd1);
        r.a1 = ((bw >> s) << (s + 4'd1)) | pos;
        r.a2 = r.a1 + half;
        r.tw = 8'(pos << (4'd8 - s));
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            b        <= '0;
            dcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            stage    <= '0;
            rd_en    <= 1'b0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
            tw_addr  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                        stage <= '0;
                        b     <= '0;
                        {rd_addr1, rd_addr2, tw_addr} <= gen_addr(4'd0, 8'd0);
                    end
                end
                READ: begin
                    if (b == 8'd255) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                        dcnt  <= '0;
                        {rd_addr1, rd_addr2, tw_addr} <= '0;
                    end else begin
                        b <= b + 8'd1;
                        {rd_addr1, rd_addr2, tw_addr} <= gen_addr(stage, b + 8'd1);
                    end
                end
                DRAIN: begin
                    // Last write of the stage must land before the next stage reads it back.
                    if (dcnt == 4'(BF_LAT)) begin
                        if (stage == 4'd8) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                            stage <= stage + 4'd1;
                            b     <= '0;
                            rd_en <= 1'b1;
                            {rd_addr1, rd_addr2, tw_addr} <= gen_addr(stage + 4'd1, 8'd0);
                        end
                    end else begin
                        dcnt <= dcnt + 4'd1;
                    end
                end
                DONE: begin
                    stage <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BF_LAT; i++) begin
                vld_pipe[i] <= 1'b0;
                a1_pipe[i]  <= '0;
                a2_pipe[i]  <= '0;
            end
        end else begin
            vld_pipe[0] <= rd_en;
            a1_pipe[0]  <= rd_addr1;
            a2_pipe[0]  <= rd_addr2;
            for (int i = 1; i < BF_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                a1_pipe[i]  <= a1_pipe[i-1];
                a2_pipe[i]  <= a2_pipe[i-1];
            end
        end
    end

    assign wr_en    = vld_pipe[BF_LAT-1];
    assign wr_addr1 = a1_pipe[BF_LAT-1];
    assign wr_addr2 = a2_pipe[BF_LAT-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Scoreboard bench for fft_stage_ctrl: expected reads/writes/done queued by stimulus, popped by a monitor.
module tb_fft_stage_ctrl;
    localparam int BF_LAT = 2;
    localparam int STG    = 256 + BF_LAT + 1;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       busy, done, rd_en, wr_en;
    logic [3:0] stage;
    logic [8:0] rd_addr1, rd_addr2, wr_addr1, wr_addr2;
    logic [7:0] tw_addr;

    fft_stage_ctrl #(.BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage(stage),
        .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .tw_addr(tw_addr),
        .wr_en(wr_en), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic [3:0] s; logic [8:0] a1; logic [8:0] a2; logic [7:0] tw;} rd_exp_t;
    typedef struct {int cyc; logic [8:0] a1; logic [8:0] a2;} wr_exp_t;
    typedef struct {int cyc; logic rd; logic [8:0] a1; logic [8:0] a2; logic [7:0] tw;
                    logic wr; logic [8:0] w1; logic [8:0] w2;} spot_t;

    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];
    int      done_q[$];
    spot_t   spot_q[$];
    rd_exp_t re;
    wr_exp_t we;
    spot_t   sp;

    int n_checks = 0;
    int n_pass   = 0;
    int base;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected reads enumerated group-by-group: group g, position p within a span of 2*half.
    task automatic push_run(input int b0, input int nfull, input int nb);
        int half, lim, bi, a1;
        for (int s = 0; s <= nfull && s < 9; s++) begin
            half = 1 << s;
            lim  = (s < nfull) ? 256 : nb;
            for (int g = 0; g < 256 / half; g++) begin
                for (int p = 0; p < half; p++) begin
                    bi = g * half + p;
                    a1 = g * 2 * half + p;
                    if (bi < lim)
                        rd_q.push_back('{b0 + s * STG + bi, 4'(s), 9'(a1), 9'(a1 + half),
                                         8'(p * (256 / half))});
                end
            end
        end
    endtask

    task automatic spot(input int c, input logic rd, input int a1, input int a2, input int tw,
                        input logic wr, input int w1, input int w2);
        spot_q.push_back('{c, rd, 9'(a1), 9'(a2), 8'(tw), wr, 9'(w1), 9'(w2)});
    endtask

    task automatic push_spots(input int b0, input bit full);
        spot(b0 + 0,    1, 0,   1,   0,   0, 0,   0);
        spot(b0 + 1,    1, 2,   3,   0,   0, 0,   0);
        spot(b0 + 2,    1, 4,   5,   0,   1, 0,   1);
        if (full) begin
            spot(b0 + 255,  1, 510, 511, 0,   1, 506, 507);
            spot(b0 + 256,  0, 0,   0,   0,   1, 508, 509);
            spot(b0 + 257,  0, 0,   0,   0,   1, 510, 511);
            spot(b0 + 258,  0, 0,   0,   0,   0, 0,   0);
            spot(b0 + 259,  1, 0,   2,   0,   0, 0,   0);
            spot(b0 + 260,  1, 1,   3,   128, 0, 0,   0);
            spot(b0 + 1053, 1, 33,  49,  16,  1, 15,  31);
            spot(b0 + 2077, 1, 5,   261, 5,   1, 3,   259);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        wait_cyc(cyc + 1);
        start = 1'b0;
    endtask

    task automatic chk_queues_empty();
        chk("rd_left",   rd_q.size(),   0);
        chk("wr_left",   wr_q.size(),   0);
        chk("done_left", done_q.size(), 0);
        chk("spot_left", spot_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_busy"},  busy,  0);
        chk({tag, "_done"},  done,  0);
        chk({tag, "_stage"}, stage, 0);
        chk({tag, "_rd_addr"}, {rd_addr1, rd_addr2, tw_addr}, 0);
        chk({tag, "_wr_addr"}, {wr_addr1, wr_addr2}, 0);
    endtask

    always @(negedge clk) begin
        if (rd_en) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                re = rd_q.pop_front();
                chk("rd_cycle", cyc, re.cyc);
                chk("rd_fields", {stage, rd_addr1, rd_addr2, tw_addr}, {re.s, re.a1, re.a2, re.tw});
                wr_q.push_back('{re.cyc + BF_LAT, re.a1, re.a2});
            end
        end
        if (wr_en) begin
            if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                we = wr_q.pop_front();
                chk("wr_cycle", cyc, we.cyc);
                chk("wr_addr", {wr_addr1, wr_addr2}, {we.a1, we.a2});
            end
        end
        if (done) begin
            if (done_q.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_cycle", cyc, done_q.pop_front());
            chk("busy_at_done", busy, 0);
        end
        if (spot_q.size() > 0 && spot_q[0].cyc == cyc) begin
            sp = spot_q.pop_front();
            chk("spot_rd", {rd_en, rd_addr1, rd_addr2, tw_addr}, {sp.rd, sp.a1, sp.a2, sp.tw});
            chk("spot_wr", {wr_en, wr_addr1, wr_addr2}, {sp.wr, sp.w1, sp.w2});
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        wait_cyc(3);
        chk_all_zero("reset");
        rst = 1'b0;

        // Full transform, with a stray start during stage 3.
        wait_cyc(10);
        base = cyc + 1;
        push_run(base, 9, 0);
        push_spots(base, 1'b1);
        done_q.push_back(base + 9 * STG);
        pulse_start();
        wait_cyc(base + 257);
        chk("busy_drain", busy, 1);
        chk("stage_drain", stage, 0);
        wait_cyc(base + 3 * STG + 10);
        chk("stage3", stage, 3);
        pulse_start();
        wait_cyc(base + 9 * STG + 1);
        chk("stage_after_done", stage, 0);
        chk("busy_after_done", busy, 0);
        chk("done_cleared", done, 0);
        wait_cyc(base + 9 * STG + 10);
        chk_queues_empty();

        // Reset in the middle of stage 4, after butterfly 19 has been read.
        base = cyc + 1;
        push_run(base, 4, 20);
        push_spots(base, 1'b0);
        pulse_start();
        wait_cyc(base + 4 * STG + 19);
        rst = 1'b1;
        wait_cyc(cyc + 1);
        chk_all_zero("midrst");
        wait_cyc(cyc + 1);
        wr_q.delete();
        rst = 1'b0;
        wait_cyc(cyc + 5);
        chk_all_zero("idle");
        chk_queues_empty();

        // Fresh start after the aborted run begins again at stage 0.
        base = cyc + 1;
        push_run(base, 9, 0);
        push_spots(base, 1'b0);
        done_q.push_back(base + 9 * STG);
        pulse_start();
        wait_cyc(base + 9 * STG + 10);
        chk_queues_empty();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fft_stage_ctrl.md
FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 SHALL have parameter BF_LAT, default 2: cycles from a read address being presented to the matching butterfly result being presented for write; legal range 1..8.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, one-cycle request to run a full 512-point transform.
REQ-005 SHALL have port busy, output, 1, high from the first read cycle until done.
REQ-006 SHALL have port done, output, 1, one-cycle pulse when all 9 stages are written back.
REQ-007 SHALL have port stage, output, 4, current stage index 0..8.
REQ-008 SHALL have port rd_en, output, 1, read strobe to the 2-port data SRAM.
REQ-009 SHALL have ports rd_addr1 and rd_addr2, output, 9 each, butterfly operand addresses.
REQ-010 SHALL have port tw_addr, output, 8, twiddle ROM index aligned with rd_addr1/rd_addr2.
REQ-011 SHALL have port wr_en, output, 1, write strobe to the data SRAM.
REQ-012 SHALL have ports wr_addr1 and wr_addr2, output, 9 each, in-place write-back addresses.

Function
REQ-013 SHALL implement FSM states IDLE, READ, DRAIN and DONE.
REQ-014 IDLE SHALL go to READ on the edge where start=1; start SHALL be ignored in every other state.
REQ-015 READ SHALL issue 256 butterflies for the stage, with index b=0..255, one per cycle, with rd_en=1 each cycle.
REQ-016 READ SHALL go to DRAIN after b=255.
REQ-017 For stage s, address generation SHALL be: half=2^s; pos=b mod half; rd_addr1=((b>>s)<<(s+1)) | pos; rd_addr2=rd_addr1+half; tw_addr=pos<<(8-s). This is radix-2 DIT on bit-reversed input.
REQ-018 rd_en, rd_addr1, rd_addr2, tw_addr and stage SHALL be registered outputs.
REQ-019 rd_en SHALL be 0 outside READ, with rd_addr1, rd_addr2 and tw_addr held at 0.
REQ-020 wr_en, wr_addr1 and wr_addr2 SHALL equal rd_en, rd_addr1 and rd_addr2 delayed by exactly BF_LAT cycles, via a valid/address shift pipeline.
REQ-021 DRAIN SHALL last BF_LAT+1 cycles, so the final write of a stage is committed (SRAM write lands one edge after wr_en) before the next stage's first read.
REQ-022 After DRAIN, if stage<8, the FSM SHALL increment stage, reset b to 0 and re-enter READ; if stage=8, it SHALL go to DONE.
REQ-023 DONE SHALL assert done=1 for exactly one cycle, clear stage to 0 and return to IDLE.
REQ-024 busy SHALL be 1 in READ and DRAIN, and 0 in IDLE and DONE.
REQ-025 No cycle SHALL have rd_en=1 while a write to the same stage is still pending beyond the drain window; read/write overlap SHALL occur only within a stage, where addresses are disjoint.
REQ-026 Run length from the first read to done SHALL be 9*(256+BF_LAT+1) cycles.

Reset
REQ-027 rst=1 SHALL force IDLE and clear every output, b and the write pipeline to 0 on the next edge, including mid-stage, discarding pending writes.
REQ-028 After reset is released, the block SHALL wait for a fresh start and then begin at stage 0.

Verification
REQ-029 Reset scenario: hold rst=1 for 3 cycles -> all outputs 0, busy=0, done=0.
REQ-030 Stage 0 scenario: start pulse at cycle T -> at T+1, rd_en=1, addr pair (0,1), tw 0; at T+2, (2,3), tw 0; at T+256, (510,511).
REQ-031 Addressing scenario: stage 1, b=1 -> (1,3), tw 128; stage 4, b=17 -> (33,49), tw 16; stage 8, b=5 -> (5,261), tw 5.
REQ-032 Write pipeline scenario with BF_LAT=2: wr_en first rises 2 cycles after rd_en, with pair (0,1); there is a 3-cycle gap with rd_en=0 between stages.
REQ-033 Completion scenario with BF_LAT=2: done pulses once, 2331 cycles after the first rd_en; a start pulse issued at stage 3 has no effect.
REQ-034 Reset-mid-operation scenario: rst=1 during stage 4 -> next edge all outputs 0; a new start restarts at stage 0 with pair (0,1).
